// File: rtl/serial_adder_if.sv
// Serial operand/result bundle for serial_adder: load enable, serial operand bit, serial sum bit.
interface serial_adder_if;
    logic control;
    logic Input;
    logic Result;

    modport master (
        output control,
        output Input,
        input  Result
    );

    modport slave (
        input  control,
        input  Input,
        output Result
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: loads A then B LSB-first, then emits A+B LSB-first through one full adder.
// Define SERIAL_ADDER_CARRY_OUT_EN to append the final carry as an extra output bit.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clock,
    input logic           reset,
    serial_adder_if.slave bus
);

    localparam int unsigned   CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

`ifdef SERIAL_ADDER_CARRY_OUT_EN
    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StAdd, StCarry} state_t;
`else
    typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StAdd} state_t;
`endif

    state_t           r_state, w_state_d;
    logic [WIDTH-1:0] r_a, w_a_d;
    logic [WIDTH-1:0] r_b, w_b_d;
    logic             r_carry, w_carry_d;
    logic [CW-1:0]    r_count, w_count_d;
    logic             r_result, w_result_d;
    logic             w_sum;
    logic             w_maj;

    assign w_sum      = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_maj      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign bus.Result = r_result;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
            r_result <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_carry  <= w_carry_d;
            r_count  <= w_count_d;
            r_result <= w_result_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_carry_d  = r_carry;
        w_count_d  = r_count;
        w_result_d = 1'b0;

        case (r_state)
            StIdle: begin
                if (bus.control) begin
                    w_a_d     = {bus.Input, r_a[WIDTH-1:1]};
                    w_count_d = CW'(1);
                    w_state_d = StLoadA;
                end
            end
            StLoadA: begin
                if (bus.control) begin
                    w_a_d = {bus.Input, r_a[WIDTH-1:1]};
                    if (r_count == LastCnt) begin
                        w_count_d = '0;
                        w_state_d = StLoadB;
                    end else begin
                        w_count_d = r_count + CW'(1);
                    end
                end
            end
            StLoadB: begin
                if (bus.control) begin
                    w_b_d = {bus.Input, r_b[WIDTH-1:1]};
                    if (r_count == LastCnt) begin
                        w_carry_d = 1'b0;
                        w_count_d = '0;
                        w_state_d = StAdd;
                    end else begin
                        w_count_d = r_count + CW'(1);
                    end
                end
            end
            StAdd: begin
                // control is deliberately ignored while the sum streams out
                w_result_d = w_sum;
                w_carry_d  = w_maj;
                w_a_d      = {1'b0, r_a[WIDTH-1:1]};
                w_b_d      = {1'b0, r_b[WIDTH-1:1]};
                if (r_count == LastCnt) begin
                    w_count_d = '0;
`ifdef SERIAL_ADDER_CARRY_OUT_EN
                    w_state_d = StCarry;
`else
                    w_state_d = StIdle;
`endif
                end else begin
                    w_count_d = r_count + CW'(1);
                end
            end
`ifdef SERIAL_ADDER_CARRY_OUT_EN
            StCarry: begin
                w_result_d = r_carry;
                w_carry_d  = 1'b0;
                w_state_d  = StIdle;
            end
`endif
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus queues expected Result bits by cycle, monitor checks.
module tb_serial_adder;

    localparam int unsigned W = 8;

`ifdef SERIAL_ADDER_CARRY_OUT_EN
    localparam int unsigned Tail = 1;
`else
    localparam int unsigned Tail = 0;
`endif

    typedef struct {
        int    due;
        logic  val;
        string nm;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    serial_adder_if bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Monitor: compares the head expectation in the period it is due.
    initial begin
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: expectation for cycle %0d never checked (now %0d)",
                         q[0].nm, q[0].due, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if (bus.Result !== e.val) begin
                    bad++;
                    $display("FAIL %s: Result=%b expected %b at cycle %0d",
                             e.nm, bus.Result, e.val, cyc);
                end
            end
        end
    end

    task automatic push(int due, logic val, string nm);
        exp_t e;
        e.due = due;
        e.val = val;
        e.nm  = nm;
        q.push_back(e);
    endtask

    task automatic drive(logic c, logic v);
        bus.control = c;
        bus.Input   = v;
        @(posedge clock);
        #1;
    endtask

    task automatic load_operand(logic [W-1:0] v, int pause_at, int pause_len);
        for (int i = 0; i < int'(W); i++) begin
            if (i == pause_at) begin
                for (int p = 0; p < pause_len; p++) drive(1'b0, 1'b0);
            end
            drive(1'b1, v[i]);
        end
    endtask

    // Loads A and B, then queues the hand-computed sum bits relative to the edge entering ADD.
    task automatic run_op(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] sum, logic cout,
                          int pause_at, int pause_len, int nbits, string nm, output int e);
        load_operand(a, pause_at, pause_len);
        load_operand(b, -1, 0);
        e = cyc;
        for (int k = 0; k < nbits; k++) push(e + 1 + k, sum[k], $sformatf("%s bit%0d", nm, k));
        if (nbits == int'(W)) begin
`ifdef SERIAL_ADDER_CARRY_OUT_EN
            push(e + int'(W) + 1, cout, {nm, " carry"});
            push(e + int'(W) + 2, 1'b0, {nm, " idle"});
`else
            push(e + int'(W) + 1, 1'b0, {nm, " idle"});
`endif
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            drive(1'b0, 1'b0);
            n++;
        end
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations pending, required 0", q.size());
            q.delete();
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic check_now(string nm, logic req);
        total++;
        if (bus.Result !== req) begin
            bad++;
            $display("FAIL %s: Result=%b required %b", nm, bus.Result, req);
        end
    endtask

    initial begin
        int e;
        bus.control = 1'b0;
        bus.Input   = 1'b0;
        #3;
        check_now("reset_state", 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle with control low: Input toggling must not produce output
        for (int i = 1; i <= 20; i++) push(cyc + i, 1'b0, "idle_quiet");
        for (int i = 0; i < 20; i++) drive(1'b0, i[0]);
        drain();

        run_op(8'h03, 8'h05, 8'h08, 1'b0, -1, 0, W, "add_03_05", e);
        drain();

        run_op(8'hFF, 8'h01, 8'h00, 1'b1, -1, 0, W, "add_ff_01", e);
        drain();

        run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, 4, 3, W, "pause_ff_ff", e);
        drain();

        // Reset mid-cycle during ADD, after three sum bits of an all-ones result
        run_op(8'hAA, 8'h55, 8'hFF, 1'b0, -1, 0, 3, "abort_aa_55", e);
        while (cyc < e + 3) drive(1'b0, 1'b0);
        #5;
        reset = 1'b1;
        #1;
        check_now("async_reset_in_add", 1'b0);
        @(posedge clock);
        #1;
        check_now("reset_held", 1'b0);
        reset = 1'b0;
        drain();

        run_op(8'h10, 8'h01, 8'h11, 1'b0, -1, 0, W, "fresh_10_01", e);
        drain();

        // Back to back, control held high with ones presented during ADD
        run_op(8'h0A, 8'h05, 8'h0F, 1'b0, -1, 0, W, "b2b_0a_05", e);
        for (int i = 0; i < int'(W + Tail); i++) drive(1'b1, 1'b1);
        run_op(8'h80, 8'h80, 8'h00, 1'b1, -1, 0, W, "b2b_80_80", e);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial two-operand adder with one serial data input.
- Operands A then B are shifted in LSB-first while `control` is high.
- The block then adds them with a single full adder and a carry flip-flop, and emits the sum LSB-first on `Result`.
- Used as a low-area arithmetic element in serial datapaths.

Parameters:
- WIDTH, 8, operand width in bits (>=2); sum width = WIDTH (carry-out only with the optional feature).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- control  input  1  load enable; Input is sampled only when high during load phase
- Input  input  1  serial operand bit
- Result  output  1  registered serial sum bit, LSB first

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset asserted (any time, including mid-load/mid-add): state=IDLE, A=0, B=0, carry=0, bit counter=0, Result=0. Operation in progress is aborted.
- States: IDLE, LOAD_A, LOAD_B, ADD (plus CARRY with the optional feature).
- IDLE:
  - Result=0.
  - Rising edge with control=1: A <= {Input, A[WIDTH-1:1]}, count=1, go LOAD_A.
  - control=0: stay in IDLE.
- LOAD_A:
  - Each edge with control=1 shifts Input into A the same way and increments count.
  - control=0 pauses: no shift, count held.
  - When the WIDTH-th A bit is captured: count=0, go LOAD_B. After this, A holds the value whose LSB was the first bit received.
- LOAD_B:
  - Same shifting and pausing rules, into B.
  - When the WIDTH-th B bit is captured: carry=0, count=0, go ADD.
- ADD:
  - Runs WIDTH edges; control is ignored.
  - Each edge: s = A[0]^B[0]^carry; Result <= s; carry <= majority(A[0],B[0],carry); A and B shift right by 1; count increments.
  - After the WIDTH-th ADD edge: go IDLE, or CARRY if the optional feature is enabled.
- Result timing:
  - Sum bit k (k=0..WIDTH-1) is driven during the clock period after ADD edge k.
  - Latency: first sum bit appears 1 cycle after entering ADD, i.e. 2*WIDTH+1 edges after the first loaded bit when control is held high.
- Return to IDLE: at the edge entering IDLE, Result <= 0.
- Carry-out is discarded unless the feature is enabled, so the sum wraps modulo 2^WIDTH.
- Back-to-back operation: control=1 on the first IDLE edge after completion starts a new load. Bits presented while in ADD/CARRY are not captured.

Optional Feature:
- Macro SERIAL_ADDER_CARRY_OUT_EN.
- Defined:
  - After the last ADD edge, the FSM enters CARRY for one edge.
  - At that edge, Result <= final carry, driven for one period; then IDLE with Result <= 0.
  - Total output length is WIDTH+1 bits.
- Undefined:
  - CARRY state is absent; ADD goes directly to IDLE.
  - Output length is WIDTH bits.

Test Plan:
- Reset asserted asynchronously mid-cycle -> Result=0 immediately; state IDLE; no Result activity with control=0 for 20 cycles.
- WIDTH=8, control=1, load A=0x03, B=0x05 (LSB-first) -> Result sequence over 8 cycles 0,0,0,1,0,0,0,0 (0x08); then Result=0.
- Load A=0xFF, B=0x01 -> Result 0x00 over 8 bits. With SERIAL_ADDER_CARRY_OUT_EN, a 9th bit of 1 follows; without it, Result=0 in the 9th cycle.
- Load A=0xFF, B=0xFF with control dropped to 0 for 3 cycles after 4 A bits -> pause honoured; Result sequence 0x FE (0,1,1,1,1,1,1,1); with the macro, carry bit 1 follows.
- Reset pulsed during ADD after 3 sum bits -> Result=0 at once. A fresh load A=0x10, B=0x01 then yields 0x11.
- Two operations back to back with control held high: 0x0A+0x05 then 0x80+0x80 -> 0x0F, then 0x00 (carry 1 with the macro); no bits captured during ADD.
